// File: rtl/hls_deadlock_watchdog_ctrl_pkg.sv
// Shared types and helpers for the deadlock watchdog controller.
package hls_deadlock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SUSPECT,
        CONFIRM,
        REPORT,
        HOLD
    } state_e;

    localparam int EVT_W = 8;

    // Ceiling log2, usable in parameter expressions; clog2(1) = 0.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hls_deadlock_watchdog_ctrl_if.sv
// Report channel from the watchdog to the debug/host side (valid/ready + payload).
interface hls_deadlock_watchdog_ctrl_if
    import hls_deadlock_pkg::*;
#(
    parameter int NUM_AXIS = 6,
    parameter int CNT_W    = 16,
    parameter int CHW      = clog2(NUM_AXIS + 1)
);
    logic                report_valid;
    logic                report_ready;
    logic [CHW-1:0]      report_chan;
    logic [NUM_AXIS-1:0] report_snapshot;
    logic [CNT_W-1:0]    report_time;

    // Watchdog side: produces the report.
    modport master (
        output report_valid,
        output report_chan,
        output report_snapshot,
        output report_time,
        input  report_ready
    );

    // Host side: consumes the report.
    modport slave (
        input  report_valid,
        input  report_chan,
        input  report_snapshot,
        input  report_time,
        output report_ready
    );
endinterface

// File: rtl/hls_deadlock_first_chan_enc.sv
// Lowest-set-bit encoder; returns N when no bit is set.
module hls_deadlock_first_chan_enc #(
    parameter int N = 6,
    parameter int W = 3
) (
    input  logic [N-1:0] vec_i,
    output logic [W-1:0] idx_o
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx_o = W'(N);
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = W'(i);
        end
    end

endmodule

// File: rtl/hls_deadlock_watchdog_ctrl.sv
// Qualifies the raw deadlock-monitor block flag into a confirmed, sticky
// deadlock event and hands a channel/time report to the host.
module hls_deadlock_watchdog_ctrl
    import hls_deadlock_pkg::*;
#(
    parameter int NUM_AXIS  = 6,
    parameter int NUM_INST  = 4,
    parameter int THRESHOLD = 16,
    parameter int CNT_W     = 16,
    parameter int CHW       = clog2(NUM_AXIS + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 monitor_block,
    input  logic [NUM_AXIS-1:0]  axis_block_sigs,
    input  logic [NUM_INST-1:0]  inst_idle_sigs,
    input  logic                 clear,
    hls_deadlock_watchdog_ctrl_if.master rpt,
    output logic                 deadlock,
    output logic [EVT_W-1:0]     event_count
);

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    qcnt_q, qcnt_d;
    logic [CNT_W-1:0]    ts_q;
    logic [NUM_AXIS-1:0] snap_q, snap_d;
    logic [NUM_AXIS-1:0] rpt_snap_q, rpt_snap_d;
    logic [CHW-1:0]      rpt_chan_q, rpt_chan_d;
    logic [CNT_W-1:0]    rpt_time_q, rpt_time_d;
    logic                dl_q, dl_d;
    logic [EVT_W-1:0]    evt_q, evt_d;
    logic [CHW-1:0]      first_chan;
    logic                blk;

    // A fully idle design cannot be deadlocked, whatever the monitor says.
    assign blk = enable & monitor_block & ~(&inst_idle_sigs);

    hls_deadlock_first_chan_enc #(
        .N (NUM_AXIS),
        .W (CHW)
    ) u_enc (
        .vec_i (snap_q),
        .idx_o (first_chan)
    );

    // Free-running timestamp; wraps naturally.
    always_ff @(posedge clock) begin
        if (reset) ts_q <= '0;
        else       ts_q <= ts_q + CNT_W'(1);
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            qcnt_q     <= '0;
            snap_q     <= '0;
            rpt_snap_q <= '0;
            rpt_chan_q <= '0;
            rpt_time_q <= '0;
            dl_q       <= 1'b0;
            evt_q      <= '0;
        end else begin
            state_q    <= state_d;
            qcnt_q     <= qcnt_d;
            snap_q     <= snap_d;
            rpt_snap_q <= rpt_snap_d;
            rpt_chan_q <= rpt_chan_d;
            rpt_time_q <= rpt_time_d;
            dl_q       <= dl_d;
            evt_q      <= evt_d;
        end
    end

    // Next-state: qualify, confirm, report, hold; clear overrides everything
    // outside IDLE (including a confirm in flight, which is then not counted).
    always_comb begin
        state_d    = state_q;
        qcnt_d     = qcnt_q;
        snap_d     = snap_q;
        rpt_snap_d = rpt_snap_q;
        rpt_chan_d = rpt_chan_q;
        rpt_time_d = rpt_time_q;
        dl_d       = dl_q;
        evt_d      = evt_q;

        case (state_q)
            IDLE: begin
                if (blk) begin
                    state_d = SUSPECT;
                    qcnt_d  = CNT_W'(1);
                    snap_d  = axis_block_sigs;
                end
            end
            SUSPECT: begin
                if (!blk) begin
                    state_d = IDLE;
                    qcnt_d  = '0;
                    snap_d  = '0;
                end else begin
                    qcnt_d = qcnt_q + CNT_W'(1);
                    snap_d = snap_q | axis_block_sigs;
                    if (qcnt_q == CNT_W'(THRESHOLD - 1)) state_d = CONFIRM;
                end
            end
            CONFIRM: begin
                rpt_chan_d = first_chan;
                rpt_snap_d = snap_q;
                rpt_time_d = ts_q;
                dl_d       = 1'b1;
                evt_d      = (evt_q == '1) ? evt_q : evt_q + EVT_W'(1);
                state_d    = REPORT;
            end
            REPORT: begin
                if (rpt.report_ready) state_d = HOLD;
            end
            HOLD: begin
                state_d = HOLD;
            end
            default: state_d = IDLE;
        endcase

        if (clear && state_q != IDLE) begin
            state_d    = IDLE;
            qcnt_d     = '0;
            snap_d     = '0;
            rpt_snap_d = '0;
            rpt_chan_d = '0;
            rpt_time_d = '0;
            dl_d       = 1'b0;
            evt_d      = evt_q;
        end
    end

    assign rpt.report_valid    = (state_q == REPORT);
    assign rpt.report_chan     = rpt_chan_q;
    assign rpt.report_snapshot = rpt_snap_q;
    assign rpt.report_time     = rpt_time_q;
    assign deadlock            = dl_q;
    assign event_count         = evt_q;

endmodule

// File: tb/tb_hls_deadlock_watchdog_ctrl.sv
// Directed bench for the deadlock watchdog controller.
module tb_hls_deadlock_watchdog_ctrl;
    import hls_deadlock_pkg::*;

    localparam int NUM_AXIS  = 6;
    localparam int NUM_INST  = 4;
    localparam int THRESHOLD = 16;
    localparam int CNT_W     = 16;

    logic                clock;
    logic                reset;
    logic                enable;
    logic                monitor_block;
    logic [NUM_AXIS-1:0] axis_block_sigs;
    logic [NUM_INST-1:0] inst_idle_sigs;
    logic                clear;
    logic                deadlock;
    logic [EVT_W-1:0]    event_count;

    int n_cmp;
    int n_err;
    logic seen;
    logic stable;

    hls_deadlock_watchdog_ctrl_if #(.NUM_AXIS(NUM_AXIS), .CNT_W(CNT_W)) rpt_if ();

    hls_deadlock_watchdog_ctrl #(
        .NUM_AXIS  (NUM_AXIS),
        .NUM_INST  (NUM_INST),
        .THRESHOLD (THRESHOLD),
        .CNT_W     (CNT_W)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable          (enable),
        .monitor_block   (monitor_block),
        .axis_block_sigs (axis_block_sigs),
        .inst_idle_sigs  (inst_idle_sigs),
        .clear           (clear),
        .rpt             (rpt_if),
        .deadlock        (deadlock),
        .event_count     (event_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_report(input string tag, input logic [31:0] chan,
                              input logic [31:0] snap, input logic [31:0] evt);
        chk({tag, "_dl"},    32'(deadlock), 32'd1);
        chk({tag, "_vld"},   32'(rpt_if.report_valid), 32'd1);
        chk({tag, "_chan"},  32'(rpt_if.report_chan), chan);
        chk({tag, "_snap"},  32'(rpt_if.report_snapshot), snap);
        chk({tag, "_evt"},   32'(event_count), evt);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clock = 1'b0;
        reset = 1'b1;
        enable = 1'b0;
        monitor_block = 1'b0;
        axis_block_sigs = '0;
        inst_idle_sigs = '0;
        clear = 1'b0;
        rpt_if.report_ready = 1'b0;
        step();
        step();

        chk("rst_dl",   32'(deadlock), 32'd0);
        chk("rst_vld",  32'(rpt_if.report_valid), 32'd0);
        chk("rst_evt",  32'(event_count), 32'd0);
        chk("rst_chan", 32'(rpt_if.report_chan), 32'd0);
        chk("rst_time", 32'(rpt_if.report_time), 32'd0);

        // 1: 16 blocked samples on channel 2; confirm visible one cycle later
        reset = 1'b0;
        enable = 1'b1;
        monitor_block = 1'b1;
        axis_block_sigs = 6'b000100;
        repeat (16) step();
        chk("t1_pre_dl", 32'(deadlock), 32'd0);
        step();
        chk_report("t1", 32'd2, 32'h04, 32'd1);
        chk("t1_time", 32'(rpt_if.report_time), 32'd16);

        // 4: host stalls; payload must not move even though inputs do
        axis_block_sigs = 6'b111111;
        stable = 1'b1;
        repeat (10) begin
            step();
            if (!(rpt_if.report_valid === 1'b1 && rpt_if.report_chan === 3'd2 &&
                  rpt_if.report_snapshot === 6'b000100 && rpt_if.report_time === 16'd16))
                stable = 1'b0;
        end
        chk("t4_stable", 32'(stable), 32'd1);
        rpt_if.report_ready = 1'b1;
        step();
        rpt_if.report_ready = 1'b0;
        chk("t4_hold_vld", 32'(rpt_if.report_valid), 32'd0);
        chk("t4_hold_dl",  32'(deadlock), 32'd1);
        repeat (3) step();
        chk("t4_hold_sticky", 32'(deadlock), 32'd1);
        clear = 1'b1;
        step();
        clear = 1'b0;
        monitor_block = 1'b0;
        chk("t4_clr_dl",  32'(deadlock), 32'd0);
        chk("t4_clr_evt", 32'(event_count), 32'd1);
        step();

        // 2: a single gap at THRESHOLD-1 restarts qualification
        seen = 1'b0;
        monitor_block = 1'b1;
        repeat (15) begin step(); seen |= deadlock | rpt_if.report_valid; end
        monitor_block = 1'b0;
        step();
        monitor_block = 1'b1;
        repeat (15) begin step(); seen |= deadlock | rpt_if.report_valid; end
        monitor_block = 1'b0;
        step();
        seen |= deadlock | rpt_if.report_valid;
        chk("t2_no_event", 32'(seen), 32'd0);

        // 3: fully idle design suppresses; dropping one idle bit qualifies
        seen = 1'b0;
        inst_idle_sigs = 4'hF;
        monitor_block = 1'b1;
        axis_block_sigs = 6'b110000;
        repeat (20) begin step(); seen |= deadlock; end
        chk("t3_idle_supp", 32'(seen), 32'd0);
        inst_idle_sigs = 4'hE;
        repeat (16) step();
        chk("t3_pre_dl", 32'(deadlock), 32'd0);
        step();
        chk_report("t3", 32'd4, 32'h30, 32'd2);

        // 5: clear together with ready, then requalify with a changing snapshot
        rpt_if.report_ready = 1'b1;
        clear = 1'b1;
        step();
        rpt_if.report_ready = 1'b0;
        clear = 1'b0;
        chk("t5_clr_vld", 32'(rpt_if.report_valid), 32'd0);
        chk("t5_clr_dl",  32'(deadlock), 32'd0);
        chk("t5_clr_evt", 32'(event_count), 32'd2);
        axis_block_sigs = 6'b001000;
        repeat (8) step();
        axis_block_sigs = 6'b100000;
        repeat (8) step();
        chk("t5_pre_dl", 32'(deadlock), 32'd0);
        step();
        chk_report("t5", 32'd3, 32'h28, 32'd3);

        // 6: empty snapshot gives the sentinel channel
        rpt_if.report_ready = 1'b1;
        step();
        rpt_if.report_ready = 1'b0;
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("t6_clr_dl", 32'(deadlock), 32'd0);
        axis_block_sigs = '0;
        repeat (17) step();
        chk_report("t6", 32'd6, 32'h00, 32'd4);

        // enable low for one sample abandons qualification
        clear = 1'b1;
        step();
        clear = 1'b0;
        axis_block_sigs = 6'b000010;
        repeat (10) step();
        enable = 1'b0;
        step();
        enable = 1'b1;
        repeat (16) step();
        chk("en_pre_dl", 32'(deadlock), 32'd0);
        step();
        chk_report("en", 32'd1, 32'h02, 32'd5);

        // reset in the middle of SUSPECT
        clear = 1'b1;
        step();
        clear = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        step();
        chk("mrst_dl",   32'(deadlock), 32'd0);
        chk("mrst_vld",  32'(rpt_if.report_valid), 32'd0);
        chk("mrst_evt",  32'(event_count), 32'd0);
        chk("mrst_chan", 32'(rpt_if.report_chan), 32'd0);
        chk("mrst_snap", 32'(rpt_if.report_snapshot), 32'd0);
        chk("mrst_time", 32'(rpt_if.report_time), 32'd0);
        reset = 1'b0;
        monitor_block = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
